// File: rtl/adder_serial_pkg.sv
// ============================================================================
// Module  : adder_serial_pkg
// Purpose : Shared types and sizing helpers for the digit-serial adder.
//           - state_t        : FSM state encoding (IDLE / CALC / DONE)
//           - calc_nsteps    : number of digit steps per operation
//           - calc_cnt_width : step counter width (minimum 1 bit)
// Config  : ADDER_SERIAL_SUB_EN (used by adder_serial, not by this package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_serial_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits needed to cover an NBITS operand when DBITS bits are added per cycle.
  function automatic int calc_nsteps(input int nbits, input int dbits);
    return nbits / dbits;
  endfunction

  // Counter must hold 0..NSTEPS-1; a single-step adder still needs one bit.
  function automatic int calc_cnt_width(input int nsteps);
    return (nsteps > 1) ? $clog2(nsteps) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_serial_digit.sv
// ============================================================================
// Module  : adder_serial_digit
// Purpose : Combinational DBITS-wide ripple of full-adder cells; one digit of
//           the serial adder.
// Ports   : a, b      [DBITS-1:0] digit operands
//           cin                   carry into the digit LSB
//           sum       [DBITS-1:0] digit sum
//           cout                  carry out of the digit MSB
//           cmsb                  carry into the digit MSB (for overflow)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_serial_digit
  import adder_serial_pkg::*;
#(
  parameter int DBITS = 1
) (
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  input  logic             cin,
  output logic [DBITS-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // carry[i] is the carry into bit i; carry[DBITS] leaves the digit.
  logic [DBITS:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DBITS; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[DBITS];
  assign cmsb = carry[DBITS-1];

endmodule

`default_nettype wire

// File: rtl/adder_serial.sv
// ============================================================================
// Module  : adder_serial
// Purpose : Digit-serial adder. Accepts two NBITS operands plus carry-in on a
//           val/rdy input stream, adds DBITS bits per cycle through a
//           registered carry, and returns sum / carry-out / signed overflow
//           on a val/rdy output stream. One operation in flight at a time.
// Ports   : clk                       rising-edge clock
//           reset                     asynchronous, active-low reset
//           istream_val / istream_rdy operand handshake
//           in0, in1    [NBITS-1:0]   operands A and B
//           cin                       carry-in
//           sub                       subtract select (ADDER_SERIAL_SUB_EN only)
//           ostream_val / ostream_rdy result handshake
//           sum         [NBITS-1:0]   A+B+cin mod 2^NBITS (0 unless valid)
//           cout                      unsigned carry-out (0 unless valid)
//           ovf                       signed overflow (0 unless valid)
// Config  : ADDER_SERIAL_SUB_EN - adds the sub port; sub=1 computes A-B by
//           capturing ~in1 with a forced carry-in of 1 (cout=1: no borrow).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int DBITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             cin,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              NSTEPS    = calc_nsteps(NBITS, DBITS);
  localparam int              CNT_W     = calc_cnt_width(NSTEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

  // Reject configurations where the operand does not split into whole digits.
  if ((DBITS < 1) || (NBITS % DBITS != 0)) begin : g_bad_config
    $error("adder_serial: NBITS (%0d) must be a positive multiple of DBITS (%0d)",
           NBITS, DBITS);
  end

  state_t             state;
  state_t             state_next;
  logic [NBITS-1:0]   a_reg;
  logic [NBITS-1:0]   b_reg;
  logic [NBITS-1:0]   sum_reg;
  logic [NBITS-1:0]   sum_shift;
  logic               carry;
  logic               ovf_reg;
  logic [CNT_W-1:0]   step;

  logic               accept;
  logic               last_step;
  logic [NBITS-1:0]   b_load;
  logic               carry_load;

  logic [DBITS-1:0]   digit_sum;
  logic               digit_cout;
  logic               digit_cmsb;

  assign accept    = istream_val && istream_rdy;
  assign last_step = (step == LAST_STEP);

`ifdef ADDER_SERIAL_SUB_EN
  // Two's-complement subtract: A + ~B + 1; the caller's cin is ignored.
  assign b_load     = sub ? ~in1 : in1;
  assign carry_load = sub | cin;
`else
  assign b_load     = in1;
  assign carry_load = cin;
`endif

  adder_serial_digit #(
    .DBITS (DBITS)
  ) u_digit (
    .a    (a_reg[DBITS-1:0]),
    .b    (b_reg[DBITS-1:0]),
    .cin  (carry),
    .sum  (digit_sum),
    .cout (digit_cout),
    .cmsb (digit_cmsb)
  );

  // Each new digit enters at the top, so after NSTEPS shifts the first digit
  // has walked down to the LSB position.
  if (NSTEPS == 1) begin : g_single_step
    assign sum_shift = digit_sum;
  end else begin : g_multi_step
    assign sum_shift = {digit_sum, sum_reg[NBITS-1:DBITS]};
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = CALC;
      CALC:    if (last_step)   state_next = DONE;
      DONE:    if (ostream_rdy) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Result ports are forced to 0 outside DONE so partial sums
  // never leak onto the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    sum         = '0;
    cout        = 1'b0;
    ovf         = 1'b0;
    case (state)
      // Gate with reset so rdy drops the moment reset asserts.
      IDLE: istream_rdy = reset;
      DONE: begin
        ostream_val = 1'b1;
        sum         = sum_reg;
        cout        = carry;
        ovf         = ovf_reg;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shift registers, carry, step counter, overflow latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      ovf_reg <= 1'b0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in0;
            b_reg <= b_load;
            carry <= carry_load;
            step  <= '0;
          end
        end
        CALC: begin
          a_reg   <= a_reg >> DBITS;
          b_reg   <= b_reg >> DBITS;
          sum_reg <= sum_shift;
          carry   <= digit_cout;
          step    <= step + 1'b1;
          // On the final digit the carries around the operand MSB are visible.
          if (last_step) begin
            ovf_reg <= digit_cmsb ^ digit_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
